// File: rtl/accumulator_serial_rx_pkg.sv
// Shared constants and FSM encoding for the accumulator serial link receiver.
package accumulator_serial_rx_pkg;

   localparam int unsigned ACC_WIDTH_DEFAULT = 16;
   localparam int unsigned NUM_WORDS_DEFAULT = 4;
   localparam int unsigned IDX_W_DEFAULT     = 2;

   // Position of each accumulator word within a frame
   localparam int unsigned WIDX_SA_I  = 0;
   localparam int unsigned WIDX_SA_Q  = 1;
   localparam int unsigned WIDX_CML_I = 2;
   localparam int unsigned WIDX_CML_Q = 3;

   typedef enum logic {
      IDLE = 1'b0,
      RX   = 1'b1
   } rx_state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/accumulator_serial_rx_sync_edge_detect.sv
// Two-flop synchronizer for one asynchronous input plus a registered
// rising-edge strobe taken from a third stage.
module sync_edge_detect (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_rise;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_rise <= r_sync & ~r_prev;
      end
   end

   assign o_sync = r_sync;
   assign o_rise = r_rise;

endmodule

// File: rtl/accumulator_serial_rx.sv
// Receive side of the accumulator serial readout link: oversamples the link,
// deserializes frames of NUM_WORDS words and offers each on a valid/ready port.
module accumulator_serial_rx
   import accumulator_serial_rx_pkg::*;
#(
   parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEFAULT,
   parameter int unsigned NUM_WORDS = NUM_WORDS_DEFAULT,
   parameter int unsigned IDX_W     = IDX_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 serialClk,
   input  logic                 serialStart,
   input  logic                 serialOut,
   output logic [ACC_WIDTH-1:0] word_data,
   output logic [IDX_W-1:0]     word_index,
   output logic                 word_valid,
   input  logic                 word_ready,
   output logic                 frame_done,
   output logic                 frame_error,
   output logic                 overflow
);

   localparam int unsigned BCW = cnt_width(ACC_WIDTH);

   logic                 w_samp;
   logic                 w_start_s;
   logic                 w_data_s;
   logic                 w_sclk_sync;
   logic                 w_start_rise;
   logic                 w_data_rise;
   logic                 w_unused_sync;

   rx_state_t            r_state;
   logic [ACC_WIDTH-1:0] r_shift;
   logic [BCW-1:0]       r_bit_cnt;
   logic [IDX_W-1:0]     r_word_cnt;

   rx_state_t            w_state_nxt;
   logic [ACC_WIDTH-1:0] w_shift_nxt;
   logic [BCW-1:0]       w_bit_cnt_nxt;
   logic [IDX_W-1:0]     w_word_cnt_nxt;
   logic                 w_word_done;
   logic                 w_frame_done_nxt;
   logic                 w_frame_error_nxt;
   logic [ACC_WIDTH-1:0] w_word_full;
   logic                 w_last_word;
   logic                 w_last_bit;

   logic [ACC_WIDTH-1:0] r_word_data;
   logic [IDX_W-1:0]     r_word_index;
   logic                 r_word_valid;
   logic                 r_frame_done;
   logic                 r_frame_error;
   logic                 r_overflow;

   logic                 w_load;
   logic                 w_drop;
   logic                 w_valid_nxt;

   // serialClk edge gives the sample strobe; start/data only need the sync copy
   sync_edge_detect u_sync_sclk (
      .i_clk   (clk),
      .i_reset (reset),
      .i_async (serialClk),
      .o_sync  (w_sclk_sync),
      .o_rise  (w_samp)
   );

   sync_edge_detect u_sync_start (
      .i_clk   (clk),
      .i_reset (reset),
      .i_async (serialStart),
      .o_sync  (w_start_s),
      .o_rise  (w_start_rise)
   );

   sync_edge_detect u_sync_data (
      .i_clk   (clk),
      .i_reset (reset),
      .i_async (serialOut),
      .o_sync  (w_data_s),
      .o_rise  (w_data_rise)
   );

   assign w_unused_sync = w_sclk_sync ^ w_start_rise ^ w_data_rise;

   assign w_word_full = {r_shift[ACC_WIDTH-2:0], w_data_s};
   assign w_last_word = (r_word_cnt == IDX_W'(NUM_WORDS - 1));
   assign w_last_bit  = (r_bit_cnt == BCW'(ACC_WIDTH - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_word_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_word_cnt <= w_word_cnt_nxt;
      end
   end

   // Framing FSM; a start bit always restarts at bit 0 of word 0
   always_comb begin
      w_state_nxt       = r_state;
      w_shift_nxt       = r_shift;
      w_bit_cnt_nxt     = r_bit_cnt;
      w_word_cnt_nxt    = r_word_cnt;
      w_word_done       = 1'b0;
      w_frame_done_nxt  = 1'b0;
      w_frame_error_nxt = 1'b0;

      if (w_samp) begin
         if (w_start_s) begin
            w_frame_error_nxt = (r_state == RX);
            w_shift_nxt       = ACC_WIDTH'(w_data_s);
            w_bit_cnt_nxt     = BCW'(1);
            w_word_cnt_nxt    = '0;
            w_state_nxt       = RX;
         end else if (r_state == RX) begin
            w_shift_nxt = w_word_full;
            if (w_last_bit) begin
               w_word_done   = 1'b1;
               w_bit_cnt_nxt = '0;
               if (w_last_word) begin
                  w_frame_done_nxt = 1'b1;
                  w_word_cnt_nxt   = '0;
                  w_state_nxt      = IDLE;
               end else begin
                  w_word_cnt_nxt = r_word_cnt + IDX_W'(1);
               end
            end else begin
               w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
            end
         end
      end
   end

   // Single holding register: a completed word is dropped only if the held one is stuck
   always_comb begin
      w_load      = w_word_done & (~r_word_valid | word_ready);
      w_drop      = w_word_done & r_word_valid & ~word_ready;
      w_valid_nxt = r_word_valid;
      if (w_load) begin
         w_valid_nxt = 1'b1;
      end else if (word_ready) begin
         w_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_word_data   <= '0;
         r_word_index  <= '0;
         r_word_valid  <= 1'b0;
         r_frame_done  <= 1'b0;
         r_frame_error <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         if (w_load) begin
            r_word_data  <= w_word_full;
            r_word_index <= r_word_cnt;
         end
         r_word_valid  <= w_valid_nxt;
         r_frame_done  <= w_frame_done_nxt;
         r_frame_error <= w_frame_error_nxt;
         r_overflow    <= r_overflow | w_drop;
      end
   end

   assign word_data   = r_word_data;
   assign word_index  = r_word_index;
   assign word_valid  = r_word_valid;
   assign frame_done  = r_frame_done;
   assign frame_error = r_frame_error;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_accumulator_serial_rx.sv
// Self-checking bench for accumulator_serial_rx: drives the serial link at 8 clk per bit
// and compares delivered words against a bitstream-level frame decoder.
module tb_accumulator_serial_rx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        serialClk = 1'b0;
   logic        serialStart = 1'b0;
   logic        serialOut = 1'b0;
   logic [15:0] word_data;
   logic [1:0]  word_index;
   logic        word_valid;
   logic        word_ready = 1'b0;
   logic        frame_done;
   logic        frame_error;
   logic        overflow;

   accumulator_serial_rx dut (
      .clk         (clk),
      .reset       (reset),
      .serialClk   (serialClk),
      .serialStart (serialStart),
      .serialOut   (serialOut),
      .word_data   (word_data),
      .word_index  (word_index),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .frame_done  (frame_done),
      .frame_error (frame_error),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic [1:0]  idx;
   } word_t;

   typedef struct {
      logic st;
      logic d;
   } sbit_t;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;

   word_t       got_q[$];
   word_t       exp_q[$];
   sbit_t       stream_q[$];
   int unsigned load_cyc_q[$];
   int unsigned lsb_q[$];
   int          frame_done_cnt = 0;
   int          frame_err_cnt = 0;
   int unsigned frame_done_cyc = 0;
   int          exp_done = 0;
   int          exp_err = 0;
   logic        prev_valid = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Passive monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (word_valid && word_ready) begin
         word_t x;
         x.data = word_data;
         x.idx  = word_index;
         got_q.push_back(x);
      end
      if (word_valid && !prev_valid) load_cyc_q.push_back(cyc);
      if (frame_done) begin
         frame_done_cnt++;
         frame_done_cyc = cyc;
      end
      if (frame_error) frame_err_cnt++;
      prev_valid = word_valid;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: split the sent bitstream at start markers; each segment yields up to
   // four whole 16-bit words, MSB first. A short segment followed by a start is an error.
   function automatic void build_expected();
      int starts[$];
      exp_q.delete();
      exp_done = 0;
      exp_err  = 0;
      for (int i = 0; i < stream_q.size(); i++)
         if (stream_q[i].st) starts.push_back(i);
      for (int k = 0; k < starts.size(); k++) begin
         int s  = starts[k];
         int e  = (k + 1 < starts.size()) ? starts[k+1] : stream_q.size();
         int nw = (e - s) / 16;
         if (nw > 4) nw = 4;
         for (int w = 0; w < nw; w++) begin
            word_t x;
            x.data = '0;
            for (int b = 0; b < 16; b++) x.data = {x.data[14:0], stream_q[s + 16*w + b].d};
            x.idx = 2'(w);
            exp_q.push_back(x);
         end
         if (nw == 4) exp_done++;
         else if (k + 1 < starts.size()) exp_err++;
      end
   endfunction

   task automatic clear_sb();
      got_q.delete();
      stream_q.delete();
      load_cyc_q.delete();
      lsb_q.delete();
      frame_done_cnt = 0;
      frame_err_cnt  = 0;
   endtask

   task automatic send_bit(input logic st, input logic d, output int unsigned rise_cyc);
      @(posedge clk); #1;
      serialClk   = 1'b0;
      serialStart = st;
      serialOut   = d;
      repeat (4) @(posedge clk);
      #1;
      serialClk = 1'b1;
      rise_cyc  = cyc;
      stream_q.push_back('{st, d});
      repeat (3) @(posedge clk);
   endtask

   // Sends bits hi..lo of w; start marks bit 15 when first is set
   task automatic send_word(input logic [15:0] w, input bit first, input int hi, input int lo);
      int unsigned rc;
      for (int i = hi; i >= lo; i--) begin
         send_bit((first && i == 15) ? 1'b1 : 1'b0, w[i], rc);
         if (i == 0) lsb_q.push_back(rc);
      end
   endtask

   task automatic send_frame(input logic [15:0] w0, w1, w2, w3);
      send_word(w0, 1'b1, 15, 0);
      send_word(w1, 1'b0, 15, 0);
      send_word(w2, 1'b0, 15, 0);
      send_word(w3, 1'b0, 15, 0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      word_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (word_data !== 16'h0 || word_index !== 2'd0) begin
         errors++;
         $display("FAIL reset_data got %h/%0d exp 0000/0", word_data, word_index);
      end
      checks++;
      if (word_valid !== 1'b0 || frame_done !== 1'b0 || frame_error !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got v%b d%b e%b o%b exp all 0", word_valid, frame_done, frame_error, overflow);
      end
      reset = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_basic();
      clear_sb();
      word_ready = 1'b1;
      send_frame(16'h1234, 16'hABCD, 16'h0001, 16'h8000);
      repeat (8) @(posedge clk);
      #1;
      build_expected();
      checks++;
      if (exp_q.size() != 4 || exp_q[0].data !== 16'h1234 || exp_q[3].data !== 16'h8000) begin
         errors++;
         $display("FAIL basic_model got %0d words exp 4", exp_q.size());
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL basic_count got %0d exp %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i].data !== exp_q[i].data || got_q[i].idx !== exp_q[i].idx) begin
            errors++;
            $display("FAIL basic_word%0d got %h/%0d exp %h/%0d", i, got_q[i].data, got_q[i].idx, exp_q[i].data, exp_q[i].idx);
         end
      end
      checks++;
      if (load_cyc_q.size() != 4) begin
         errors++;
         $display("FAIL basic_loads got %0d exp 4", load_cyc_q.size());
      end
      for (int i = 0; i < load_cyc_q.size() && i < lsb_q.size(); i++) begin
         checks++;
         if (load_cyc_q[i] != lsb_q[i] + 4) begin
            errors++;
            $display("FAIL basic_latency%0d got %0d exp %0d", i, load_cyc_q[i] - lsb_q[i], 4);
         end
      end
      checks++;
      if (frame_done_cnt != 1 || load_cyc_q.size() < 4 || frame_done_cyc != load_cyc_q[3]) begin
         errors++;
         $display("FAIL basic_frame_done got cnt %0d at %0d exp 1 at load of index 3", frame_done_cnt, frame_done_cyc);
      end
      checks++;
      if (frame_err_cnt != 0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL basic_flags got err %0d ovf %b exp 0 0", frame_err_cnt, overflow);
      end
   endtask

   task automatic test_idle_bits();
      int          n;
      int unsigned rc;
      clear_sb();
      word_ready = 1'b1;
      n = $urandom_range(20, 3);
      for (int i = 0; i < n; i++) send_bit(1'b0, 1'($urandom), rc);
      send_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      repeat (8) @(posedge clk);
      #1;
      build_expected();
      checks++;
      if (got_q.size() != exp_q.size() || exp_done != frame_done_cnt) begin
         errors++;
         $display("FAIL idle_count got %0d words %0d frames exp %0d words %0d frames", got_q.size(), frame_done_cnt, exp_q.size(), exp_done);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i].data !== exp_q[i].data || got_q[i].idx !== exp_q[i].idx) begin
            errors++;
            $display("FAIL idle_word%0d got %h/%0d exp %h/%0d", i, got_q[i].data, got_q[i].idx, exp_q[i].data, exp_q[i].idx);
         end
      end
   endtask

   task automatic test_resync();
      clear_sb();
      word_ready = 1'b1;
      send_word(16'($urandom), 1'b1, 15, 0);
      send_word(16'($urandom), 1'b0, 15, 0);
      send_word(16'($urandom), 1'b0, 15, 11);
      send_frame(16'h0F0F, 16'hF0F0, 16'h5555, 16'hAAAA);
      repeat (8) @(posedge clk);
      #1;
      build_expected();
      checks++;
      if (frame_err_cnt != exp_err || frame_err_cnt != 1) begin
         errors++;
         $display("FAIL resync_error got %0d exp %0d", frame_err_cnt, exp_err);
      end
      checks++;
      if (got_q.size() != exp_q.size() || frame_done_cnt != exp_done) begin
         errors++;
         $display("FAIL resync_count got %0d words %0d frames exp %0d words %0d frames", got_q.size(), frame_done_cnt, exp_q.size(), exp_done);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i].data !== exp_q[i].data || got_q[i].idx !== exp_q[i].idx) begin
            errors++;
            $display("FAIL resync_word%0d got %h/%0d exp %h/%0d", i, got_q[i].data, got_q[i].idx, exp_q[i].data, exp_q[i].idx);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit done = 1'b0;
      clear_sb();
      fork
         begin
            for (int f = 0; f < 2; f++)
               send_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            repeat (8) @(posedge clk);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               word_ready = ~word_ready;
            end
         end
      join
      word_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      build_expected();
      checks++;
      if (got_q.size() != exp_q.size() || got_q.size() != 8) begin
         errors++;
         $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i].data !== exp_q[i].data || got_q[i].idx !== exp_q[i].idx) begin
            errors++;
            $display("FAIL b2b_word%0d got %h/%0d exp %h/%0d", i, got_q[i].data, got_q[i].idx, exp_q[i].data, exp_q[i].idx);
         end
      end
      checks++;
      if (overflow !== 1'b0 || frame_done_cnt != exp_done) begin
         errors++;
         $display("FAIL b2b_flags got ovf %b frames %0d exp ovf 0 frames %0d", overflow, frame_done_cnt, exp_done);
      end
   endtask

   task automatic test_no_ready();
      clear_sb();
      word_ready = 1'b0;
      send_word(16'h1111, 1'b1, 15, 0);
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (word_valid !== 1'b1 || word_data !== 16'h1111 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL noready_first got v%b %h ovf %b exp v1 1111 ovf 0", word_valid, word_data, overflow);
      end
      send_word(16'h2222, 1'b0, 15, 0);
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (overflow !== 1'b1 || word_data !== 16'h1111) begin
         errors++;
         $display("FAIL noready_second got ovf %b data %h exp ovf 1 data 1111", overflow, word_data);
      end
      send_word(16'h3333, 1'b0, 15, 0);
      send_word(16'h4444, 1'b0, 15, 0);
      repeat (8) @(posedge clk);
      #1;
      build_expected();
      checks++;
      if (word_data !== exp_q[0].data || word_index !== exp_q[0].idx || overflow !== 1'b1) begin
         errors++;
         $display("FAIL noready_hold got %h/%0d ovf %b exp %h/%0d ovf 1", word_data, word_index, overflow, exp_q[0].data, exp_q[0].idx);
      end
      checks++;
      if (frame_done_cnt != exp_done || got_q.size() != 0) begin
         errors++;
         $display("FAIL noready_frame got frames %0d xfers %0d exp %0d 0", frame_done_cnt, got_q.size(), exp_done);
      end
      word_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (got_q.size() != 1 || word_valid !== 1'b0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL noready_release got xfers %0d v%b ovf %b exp 1 v0 ovf1", got_q.size(), word_valid, overflow);
      end else begin
         checks++;
         if (got_q[0].data !== exp_q[0].data || got_q[0].idx !== exp_q[0].idx) begin
            errors++;
            $display("FAIL noready_xfer got %h/%0d exp %h/%0d", got_q[0].data, got_q[0].idx, exp_q[0].data, exp_q[0].idx);
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [15:0] w1;
      clear_sb();
      word_ready = 1'b0;
      w1 = 16'($urandom);
      send_word(16'($urandom), 1'b1, 15, 0);
      send_word(w1, 1'b0, 15, 11);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (word_data !== 16'h0 || word_index !== 2'd0 || word_valid !== 1'b0) begin
         errors++;
         $display("FAIL midreset_data got %h/%0d v%b exp 0000/0 v0", word_data, word_index, word_valid);
      end
      checks++;
      if (frame_done !== 1'b0 || frame_error !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL midreset_flags got d%b e%b o%b exp 0 0 0", frame_done, frame_error, overflow);
      end
      reset = 1'b0;
      word_ready = 1'b1;
      clear_sb();
      send_word(w1, 1'b0, 10, 0);
      send_word(16'($urandom), 1'b0, 15, 0);
      send_word(16'($urandom), 1'b0, 15, 0);
      send_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      repeat (8) @(posedge clk);
      #1;
      build_expected();
      checks++;
      if (got_q.size() != exp_q.size() || got_q.size() != 4 || frame_done_cnt != 1 || frame_err_cnt != 0) begin
         errors++;
         $display("FAIL midreset_count got %0d words %0d frames %0d errs exp 4 1 0", got_q.size(), frame_done_cnt, frame_err_cnt);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i].data !== exp_q[i].data || got_q[i].idx !== exp_q[i].idx) begin
            errors++;
            $display("FAIL midreset_word%0d got %h/%0d exp %h/%0d", i, got_q[i].data, got_q[i].idx, exp_q[i].data, exp_q[i].idx);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_idle_bits();
      test_resync();
      test_back_to_back();
      test_no_ready();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
